// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states,
// owner codes and the fixed byte-enable pattern used for fetches.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    localparam logic ARB_OWN_IF = 1'b0;
    localparam logic ARB_OWN_DM = 1'b1;

    // Fetches always read the full word.
    localparam logic [3:0] ARB_SEL_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// Handshake: a requester raises req with its payload and holds both stable
// until it sees gnt (a one-cycle pulse meaning the payload was captured);
// it may then drop req or present its next request. done is a one-cycle
// pulse marking completion; rdata is valid while done is high and holds
// afterwards. The memory side has no back-pressure: mem_en is a strobe.
// modport slave  : the arbiter's view.
// modport master : the view of the requesters plus memory (e.g. a bench).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_sel;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_done, if_rdata,
        input  dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        output dm_gnt, dm_done, dm_rdata,
        output mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_done, if_rdata,
        output dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
        input  dm_gnt, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_sel, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating 4-bit count of consecutive contested DM wins.
// Any IF win clears it; uncontested DM wins leave it alone. at_limit tells
// the arbiter to hand the next contested slot to the fetch port.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_dm,
    input  logic grant_if,
    input  logic contested,
    output logic at_limit
);
    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt;

    // Count contested DM wins, clear on fetch wins, saturate at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (grant_if) begin
            cnt <= 4'd0;
        end else if (grant_dm && contested && (cnt != LIM)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_limit = (cnt == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data access. Fixed-latency FSM: IDLE -> ACCESS (1) -> WAIT (MEM_LAT)
// -> RESP (1), with a new winner sampled in IDLE or RESP. DM has priority;
// the starvation counter forces an IF win after STARVE_LIMIT contested DM
// wins. Optional performance counters under `MEM_ARB_PERF_EN`.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus,
    output logic                  busy,
    output logic [1:0]            dbg_state
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_grants,
    output logic [31:0]           perf_dm_grants,
    output logic [31:0]           perf_stall_cycles
`endif
);
    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    arb_state_t        state, state_nxt;
    logic              owner;
    logic              lat_we;
    logic [3:0]        lat_sel;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        wait_cnt;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic sample, contested, pick_if, at_limit, last_wait;
    logic if_gnt_w, dm_gnt_w;

    // Requests only matter in IDLE/RESP; req level elsewhere is ignored.
    assign sample    = ((state == ARB_IDLE) || (state == ARB_RESP)) &&
                       (bus.if_req || bus.dm_req);
    assign contested = bus.if_req && bus.dm_req;
    assign pick_if   = bus.if_req && (!bus.dm_req || at_limit);
    assign last_wait = (state == ARB_WAIT) && (wait_cnt == 3'd0);

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .grant_dm  (sample && !pick_if),
        .grant_if  (sample && pick_if),
        .contested (contested),
        .at_limit  (at_limit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: fixed ACCESS/WAIT/RESP sequence, resample at RESP.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE, ARB_RESP: state_nxt = sample ? ARB_ACCESS : ARB_IDLE;
            ARB_ACCESS:         state_nxt = ARB_WAIT;
            ARB_WAIT:           if (wait_cnt == 3'd0) state_nxt = ARB_RESP;
            default:            state_nxt = ARB_IDLE;
        endcase
    end

    // Latch the winner's payload; it keeps driving mem_* until the next win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= ARB_OWN_IF;
            lat_we    <= 1'b0;
            lat_sel   <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (sample) begin
            owner     <= pick_if ? ARB_OWN_IF : ARB_OWN_DM;
            lat_we    <= pick_if ? 1'b0 : bus.dm_we;
            lat_sel   <= pick_if ? ARB_SEL_ALL : bus.dm_sel;
            lat_addr  <= pick_if ? bus.if_addr : bus.dm_addr;
            lat_wdata <= pick_if ? '0 : bus.dm_wdata;
        end
    end

    // Memory latency down-counter, loaded during ACCESS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 3'd0;
        end else if (state == ARB_ACCESS) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ARB_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Capture read data into the owner's register on the final WAIT edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (last_wait) begin
            if (owner == ARB_OWN_IF) if_rdata_q <= bus.mem_rdata;
            else                     dm_rdata_q <= lat_we ? '0 : bus.mem_rdata;
        end
    end

    assign if_gnt_w      = (state == ARB_ACCESS) && (owner == ARB_OWN_IF);
    assign dm_gnt_w      = (state == ARB_ACCESS) && (owner == ARB_OWN_DM);
    assign bus.if_gnt    = if_gnt_w;
    assign bus.dm_gnt    = dm_gnt_w;
    assign bus.if_done   = (state == ARB_RESP) && (owner == ARB_OWN_IF);
    assign bus.dm_done   = (state == ARB_RESP) && (owner == ARB_OWN_DM);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = (state == ARB_ACCESS);
    assign bus.mem_we    = (state == ARB_ACCESS) && lat_we;
    assign bus.mem_sel   = lat_sel;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign busy          = (state != ARB_IDLE);
    assign dbg_state     = state;

`ifdef MEM_ARB_PERF_EN
    // Grant and stall counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_grants    <= 32'd0;
            perf_dm_grants    <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (if_gnt_w) perf_if_grants <= perf_if_grants + 32'd1;
            if (dm_gnt_w) perf_dm_grants <= perf_dm_grants + 32'd1;
            if ((bus.if_req || bus.dm_req) && !(if_gnt_w || dm_gnt_w))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 backed by
// a byte-writable memory model, one with MEM_LAT=3 backed by an
// address-derived data pattern. Expected read data goes into exp_q when a
// request is driven and is popped when done is seen.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic reset;
    logic busy1, busy3;
    logic [1:0] dbg1, dbg3;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] p1_if, p1_dm, p1_st, p3_if, p3_dm, p3_st;
`endif

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset), .bus(a1), .busy(busy1), .dbg_state(dbg1)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_grants(p1_if), .perf_dm_grants(p1_dm), .perf_stall_cycles(p1_st)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .reset(reset), .bus(a3), .busy(busy3), .dbg_state(dbg3)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_grants(p3_if), .perf_dm_grants(p3_dm), .perf_stall_cycles(p3_st)
`endif
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model for dut1: byte-enable writes, read data from the address
    // captured in the access cycle.
    logic [31:0] mem1 [0:255];
    logic [31:0] rd_addr1;
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (pre_en) begin
            mem1[pre_idx] <= pre_data;
        end else if (a1.mem_en) begin
            rd_addr1 <= a1.mem_addr;
            if (a1.mem_we)
                for (int b = 0; b < 4; b++)
                    if (a1.mem_sel[b]) mem1[a1.mem_addr[9:2]][8*b +: 8] <= a1.mem_wdata[8*b +: 8];
        end
    end
    assign a1.mem_rdata = mem1[rd_addr1[9:2]];

    // Memory model for dut3: data = address ^ A5A50000.
    logic [31:0] rd_addr3;
    always @(posedge clk) if (a3.mem_en) rd_addr3 <= a3.mem_addr;
    assign a3.mem_rdata = rd_addr3 ^ 32'hA5A5_0000;

    // Stall-cycle reference for dut1: some req high and no gnt this cycle.
    int st_cnt;
    always @(negedge clk) begin
        if (!reset) st_cnt = 0;
        else if ((a1.if_req || a1.dm_req) && !(a1.if_gnt || a1.dm_gnt)) st_cnt = st_cnt + 1;
    end

    // Scoreboard.
    logic [31:0] exp_q[$];
    logic        own_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        tick();
        pre_en = 1'b0;
    endtask

    // One isolated DM access on dut1 (MEM_LAT=1): gnt next cycle, done two later.
    task automatic dm_op(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rexp);
        a1.dm_req = 1'b1; a1.dm_we = we; a1.dm_sel = sel;
        a1.dm_addr = addr; a1.dm_wdata = wdata;
        exp_q.push_back(rexp);
        tick();
        chk({tag, "_gnt"}, a1.dm_gnt, 1);
        chk({tag, "_mem_we"}, a1.mem_we, we);
        chk({tag, "_mem_sel"}, a1.mem_sel, sel);
        a1.dm_req = 1'b0;
        tick();
        chk({tag, "_early_done"}, a1.dm_done, 0);
        tick();
        chk({tag, "_done"}, a1.dm_done, 1);
        if (a1.dm_done) chk({tag, "_rdata"}, a1.dm_rdata, exp_q.pop_front());
        tick();
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, done_k, busy_cnt, done_seen;
        logic own;
        reset = 1'b0; pre_en = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
        a1.if_req = 0; a1.if_addr = 0; a1.dm_req = 0; a1.dm_we = 0;
        a1.dm_sel = 0; a1.dm_addr = 0; a1.dm_wdata = 0;
        a3.if_req = 0; a3.if_addr = 0; a3.dm_req = 0; a3.dm_we = 0;
        a3.dm_sel = 0; a3.dm_addr = 0; a3.dm_wdata = 0;

        // Reset state.
        tick(); tick();
        chk("rst_busy", busy1, 0);
        chk("rst_state", dbg1, 0);
        chk("rst_mem_en", a1.mem_en, 0);
        chk("rst_mem_addr", a1.mem_addr, 0);
        chk("rst_gnts", {a1.if_gnt, a1.dm_gnt, a1.if_done, a1.dm_done}, 0);
        chk("rst_if_rdata", a1.if_rdata, 0);
        chk("rst_dm_rdata", a1.dm_rdata, 0);
        preload(8'd0, 32'h3C01_0001);  // address 0x3000
        preload(8'd4, 32'h1122_3344);  // address 0x10
        reset = 1'b1;
        tick();

        // Fetch read.
        a1.if_req = 1'b1; a1.if_addr = 32'h3000;
        exp_q.push_back(32'h3C01_0001);
        tick();
        chk("fetch_gnt", a1.if_gnt, 1);
        chk("fetch_mem_en", a1.mem_en, 1);
        chk("fetch_mem_addr", a1.mem_addr, 32'h3000);
        chk("fetch_mem_sel", a1.mem_sel, 4'hF);
        chk("fetch_mem_we", a1.mem_we, 0);
        a1.if_req = 1'b0;
        tick();
        chk("fetch_wait_en", a1.mem_en, 0);
        chk("fetch_addr_hold", a1.mem_addr, 32'h3000);
        chk("fetch_early_done", a1.if_done, 0);
        tick();
        chk("fetch_done", a1.if_done, 1);
        if (a1.if_done) chk("fetch_rdata", a1.if_rdata, exp_q.pop_front());
        tick();
        chk("fetch_idle", busy1, 0);

        // Byte store, readback, and a store with no byte enables.
        dm_op("store", 1'b1, 4'b0010, 32'h10, 32'h0000_AB00, 32'h0);
        chk("store_if_rdata_hold", a1.if_rdata, 32'h3C01_0001);
        dm_op("load", 1'b0, 4'hF, 32'h10, 32'h0, 32'h1122_AB44);
        dm_op("sel0", 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 32'h0);
        dm_op("load2", 1'b0, 4'hF, 32'h10, 32'h0, 32'h1122_AB44);

        // Contention from a clean reset: DM x4, IF, DM x4, IF, 3 cycles apart.
        reset = 1'b0; tick(); reset = 1'b1; tick();
        for (int g = 0; g < 10; g++) own_q.push_back((g % 5 == 4) ? ARB_OWN_IF : ARB_OWN_DM);
        a1.if_req = 1'b1; a1.if_addr = 32'h3000;
        a1.dm_req = 1'b1; a1.dm_we = 1'b0; a1.dm_sel = 4'hF; a1.dm_addr = 32'h10;
        for (int g = 0; g < 10; g++) begin
            k = 0;
            do begin tick(); k++; end while (!(a1.if_gnt || a1.dm_gnt) && k < 10);
            chk($sformatf("cont_gap%0d", g), k, (g == 0) ? 1 : 3);
            own = a1.if_gnt ? ARB_OWN_IF : ARB_OWN_DM;
            chk($sformatf("cont_owner%0d", g), own, own_q.pop_front());
            if (g == 9) begin a1.if_req = 1'b0; a1.dm_req = 1'b0; end
        end
        repeat (4) tick();
        chk("cont_idle", busy1, 0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_dm", p1_dm, 8);
        chk("perf_if", p1_if, 2);
        chk("perf_stall", p1_st, st_cnt);
        chk("perf_stall_abs", p1_st, 19);
`endif

        // MEM_LAT=3 single load.
        a3.dm_req = 1'b1; a3.dm_we = 1'b0; a3.dm_sel = 4'hF; a3.dm_addr = 32'h40;
        exp_q.push_back(32'hA5A5_0040);
        done_k = 0; busy_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin chk("lat3_gnt", a3.dm_gnt, 1); a3.dm_req = 1'b0; end
            if (busy3) busy_cnt++;
            if (a3.dm_done && done_k == 0) begin
                done_k = i;
                chk("lat3_rdata", a3.dm_rdata, exp_q.pop_front());
            end
        end
        chk("lat3_done_cycle", done_k, 5);
        chk("lat3_busy_cycles", busy_cnt, 5);

        // Reset during WAIT drops the access.
        a1.if_req = 1'b1; a1.if_addr = 32'h3000;
        tick();
        chk("rmid_gnt", a1.if_gnt, 1);
        a1.if_req = 1'b0;
        tick();
        chk("rmid_in_wait", dbg1, 2);
        #2 reset = 1'b0;
        #1;
        chk("rmid_busy", busy1, 0);
        chk("rmid_mem_en", a1.mem_en, 0);
        chk("rmid_if_rdata", a1.if_rdata, 0);
        tick(); tick();
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a1.if_done || a1.dm_done) done_seen++;
        end
        chk("rmid_no_done", done_seen, 0);
        a1.if_req = 1'b1; a1.if_addr = 32'h3000;
        exp_q.push_back(32'h3C01_0001);
        tick();
        chk("rmid_fresh_gnt", a1.if_gnt, 1);
        a1.if_req = 1'b0;
        tick(); tick();
        chk("rmid_fresh_done", a1.if_done, 1);
        if (a1.if_done) chk("rmid_fresh_rdata", a1.if_rdata, exp_q.pop_front());
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
